// File: rtl/uwasic_onboarding_saad_syed.sv
// rtl/uwasic_onboarding_saad_syed.sv - SPI-programmed 16-output driver with shared PWM
//
// Purpose: write-only SPI (mode 0, MSB first) register file controlling 16
// outputs, each forced low, held high, or driven by one shared PWM signal.
// Ports:
//   clk      system clock (10 MHz nominal)
//   rst_n    asynchronous active-low reset
//   ena      tile enable (ignored)
//   ui_in    [0]=SCLK, [1]=COPI, [2]=nCS, [7:3] unused
//   uo_out   out[7:0]
//   uio_in   unused
//   uio_out  out[15:8]
//   uio_oe   constant 8'hFF
module uwasic_onboarding_saad_syed #(
  parameter int SYNC_STAGES = 2,
  parameter int PWM_CLK_DIV = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int PS_W = (PWM_CLK_DIV > 1) ? $clog2(PWM_CLK_DIV) : 1;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:3]};

  // Input synchronizers; the newest sample enters at bit 0.
  logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
  logic sclk_prev_q, ncs_prev_q;
  logic sclk_s, copi_s, ncs_s;
  logic sclk_rise, ncs_fall, ncs_rise;

  // SPI frame state and register file.
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] shift_q, shift_d;
  logic [15:0] en_out_q, en_out_d;
  logic [15:0] en_pwm_q, en_pwm_d;
  logic [7:0]  duty_q, duty_d;
  logic        commit;

  // PWM state and registered outputs.
  logic [PS_W-1:0] presc_q, presc_d;
  logic [7:0]      pwm_cnt_q, pwm_cnt_d;
  logic            pwm;
  logic [15:0]     out_q, out_d;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s    = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign ncs_fall  = ~ncs_s & ncs_prev_q;
  assign ncs_rise  = ncs_s & ~ncs_prev_q;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    en_out_d  = en_out_q;
    en_pwm_d  = en_pwm_q;
    duty_d    = duty_q;

    if (ncs_fall) begin
      bit_cnt_d = 5'd0;
      shift_d   = 16'd0;
    end else if (!ncs_s && sclk_rise) begin
      if (bit_cnt_q < 5'd16) begin
        shift_d   = {shift_q[14:0], copi_s};
        bit_cnt_d = bit_cnt_q + 5'd1;
      end else begin
        // Extra bits leave the captured word alone; 17 marks an overlong frame.
        bit_cnt_d = 5'd17;
      end
    end

    commit = ncs_rise && (bit_cnt_q == 5'd16) && shift_q[15] && (shift_q[14:8] <= 7'd4);

    if (commit) begin
      case (shift_q[14:8])
        7'd0:    en_out_d[7:0]  = shift_q[7:0];
        7'd1:    en_out_d[15:8] = shift_q[7:0];
        7'd2:    en_pwm_d[7:0]  = shift_q[7:0];
        7'd3:    en_pwm_d[15:8] = shift_q[7:0];
        default: duty_d         = shift_q[7:0];
      endcase
    end
  end

  always_comb begin
    presc_d   = presc_q;
    pwm_cnt_d = pwm_cnt_q;
    if (presc_q == PS_W'(PWM_CLK_DIV - 1)) begin
      presc_d   = '0;
      pwm_cnt_d = pwm_cnt_q + 8'd1;
    end else begin
      presc_d = presc_q + PS_W'(1);
    end
    // 0xFF must be solid high; a plain compare would drop one step per period.
    pwm   = (duty_q == 8'hFF) ? 1'b1 : (pwm_cnt_q < duty_q);
    out_d = en_out_q & (~en_pwm_q | {16{pwm}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b0;
      bit_cnt_q   <= 5'd0;
      shift_q     <= 16'd0;
      en_out_q    <= 16'd0;
      en_pwm_q    <= 16'd0;
      duty_q      <= 8'd0;
      presc_q     <= '0;
      pwm_cnt_q   <= 8'd0;
      out_q       <= 16'd0;
    end else begin
      sclk_sync_q <= SYNC_STAGES'({sclk_sync_q, ui_in[0]});
      copi_sync_q <= SYNC_STAGES'({copi_sync_q, ui_in[1]});
      ncs_sync_q  <= SYNC_STAGES'({ncs_sync_q, ui_in[2]});
      sclk_prev_q <= sclk_s;
      ncs_prev_q  <= ncs_s;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      en_out_q    <= en_out_d;
      en_pwm_q    <= en_pwm_d;
      duty_q      <= duty_d;
      presc_q     <= presc_d;
      pwm_cnt_q   <= pwm_cnt_d;
      out_q       <= out_d;
    end
  end

  assign uo_out  = out_q[7:0];
  assign uio_out = out_q[15:8];
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_uwasic_onboarding_saad_syed.sv
// tb/tb_uwasic_onboarding_saad_syed.sv - directed bench for the SPI PWM output tile
module tb_uwasic_onboarding_saad_syed;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h04;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  uwasic_onboarding_saad_syed dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in),
    .uo_out(uo_out), .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #50 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shift out the top nbits of word, MSB first; SCLK = clk/8.
  task automatic spi_bits(input logic [15:0] word, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ui_in[1] = word[15 - i];
      clks(4);
      ui_in[0] = 1'b1;
      clks(4);
      ui_in[0] = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [15:0] word, input int nbits);
    ui_in[2] = 1'b0;
    clks(4);
    spi_bits(word, nbits);
    clks(4);
    ui_in[2] = 1'b1;
    clks(8);
  endtask

  // Wait until uo_out[0] equals val; ok cleared on timeout.
  task automatic wait_bit0(input logic val, inout bit ok);
    int n = 0;
    while (uo_out[0] !== val && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (uo_out[0] !== val) ok = 1'b0;
  endtask

  task automatic count_high(input int n, output int highs);
    highs = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (uo_out[0]) highs++;
    end
  endtask

  initial begin
    bit ok;
    int t0, t1, t2, highs;

    clks(5);
    chk("reset uo_out", uo_out, 8'h00);
    chk("reset uio_out", uio_out, 8'h00);
    chk("reset uio_oe", uio_oe, 8'hFF);
    rst_n = 1'b1;
    clks(10);
    chk("idle uo_out", uo_out, 8'h00);

    spi_frame(16'h80F0, 16);
    chk("write reg0", uo_out, 8'hF0);
    spi_frame(16'h81CC, 16);
    chk("write reg1", uio_out, 8'hCC);
    spi_frame(16'h00FF, 16);
    chk("read frame ignored", uo_out, 8'hF0);
    spi_frame(16'hB0AA, 16);
    chk("addr 0x30 uo", uo_out, 8'hF0);
    chk("addr 0x30 uio", uio_out, 8'hCC);
    spi_frame(16'h85FF, 16);
    chk("addr 5 uo", uo_out, 8'hF0);
    chk("addr 5 uio", uio_out, 8'hCC);
    spi_frame(16'h80FF, 12);
    chk("12-bit frame", uo_out, 8'hF0);

    spi_frame(16'h8001, 16);
    spi_frame(16'h8201, 16);
    spi_frame(16'h8480, 16);
    chk("pwm uio untouched", uio_out, 8'hCC);
    ok = 1'b1;
    wait_bit0(1'b0, ok);
    wait_bit0(1'b1, ok);
    t0 = cyc;
    wait_bit0(1'b0, ok);
    t1 = cyc;
    wait_bit0(1'b1, ok);
    t2 = cyc;
    chk("pwm edges seen", ok, 1'b1);
    chk("pwm period", t2 - t0, 256 * 13);
    chk("pwm high time", t1 - t0, 128 * 13);

    spi_frame(16'h8400, 16);
    count_high(3500, highs);
    chk("duty 0 highs", highs, 0);
    spi_frame(16'h84FF, 16);
    count_high(3500, highs);
    chk("duty ff highs", highs, 3500);

    ui_in[2] = 1'b0;
    clks(4);
    spi_bits(16'h8102, 8);
    rst_n = 1'b0;
    clks(3);
    chk("mid-frame reset uo", uo_out, 8'h00);
    chk("mid-frame reset uio", uio_out, 8'h00);
    chk("mid-frame reset oe", uio_oe, 8'hFF);
    ui_in = 8'h04;
    clks(2);
    rst_n = 1'b1;
    clks(10);
    spi_frame(16'h8001, 16);
    chk("post-reset write uo", uo_out, 8'h01);
    chk("post-reset uio cleared", uio_out, 8'h00);
    count_high(200, highs);
    chk("post-reset pwm cleared", highs, 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
